// File: rtl/axis_rr_arbiter.sv
// Round-robin N:1 AXI-Stream arbiter. Beat-level rotation by default; AXIS_ARB_PACKET_LOCK_EN holds a grant to packet end or MAX_BURST beats.
// One registered output stage (1-cycle latency), one IDLE bubble per grant; owner tready follows the output register's free slot.
module axis_rr_arbiter #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [N-1:0]            s_axis_tvalid,
  output logic [N-1:0]            s_axis_tready,
  input  logic [N*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N-1:0]            s_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic [N-1:0]            grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state, state_nxt;
  logic [1:0]            rst_sync;
  logic                  rst_n;
  logic [IW-1:0]         ptr, owner, win, cand;
  logic                  win_found;
  logic [N-1:0]          win_oh;
  logic [7:0]            cnt;
  logic                  out_free, accept, rel;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  owner_last;

  // Assert asynchronously, release two edges after aresetn rises.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_comb begin
    win       = '0;
    win_found = 1'b0;
    cand      = '0;
    win_oh    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!win_found && s_axis_tvalid[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
    win_oh[win] = 1'b1;
  end

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < N; i++) begin
      if (owner == IW'(i)) owner_data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign owner_last    = s_axis_tlast[owner];
  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign accept        = (state == GRANT) && s_axis_tvalid[owner] && out_free;
  assign s_axis_tready = ((state == GRANT) && out_free) ? grant : '0;

`ifdef AXIS_ARB_PACKET_LOCK_EN
  assign rel = owner_last || (cnt == 8'(MAX_BURST - 1));
`else
  assign rel = 1'b1;
`endif

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (win_found) state_nxt = GRANT;
      GRANT: if (accept && rel) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      ptr           <= IW'(N - 1);
      owner         <= '0;
      grant         <= '0;
      cnt           <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (state == IDLE && win_found) begin
        owner <= win;
        grant <= win_oh;
        cnt   <= '0;
      end
      if (accept) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= owner_data;
        m_axis_tlast  <= owner_last;
        // Saturate so the count never wraps on long beat-level runs.
        if (cnt != 8'(MAX_BURST)) cnt <= cnt + 8'd1;
        if (rel) begin
          ptr   <= owner;
          grant <= '0;
        end
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: per-requester beat queues drive the inputs,
// expected output beats and grant owners are queued and popped by a monitor.
module tb_axis_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  typedef logic [8:0] beat_t;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [N-1:0]    s_axis_tvalid, s_axis_tready, s_axis_tlast, grant;
  logic [N*DW-1:0] s_axis_tdata;
  logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [DW-1:0]   m_axis_tdata;

  always #5 aclk = ~aclk;

  axis_rr_arbiter #(.N(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .grant(grant)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge aclk) cyc++;

  beat_t        rq [N][$];
  beat_t        exp_q[$];
  logic [N-1:0] exp_g[$];
  logic         force_vld = 1'b1;
  logic         mrdy = 1'b1;
  logic [N-1:0] hs;
  int           present_cyc [N];
  int           grant_cyc = 0;
  int           out_cyc = 0;
  logic [N-1:0] prev_g = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic bit pending();
    bit p = (exp_q.size() != 0) || (exp_g.size() != 0) || m_axis_tvalid;
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  // Driver: pop beats the DUT accepted, then present the next heads.
  initial begin
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b1;
    forever begin
      @(negedge aclk);
      hs = s_axis_tvalid & s_axis_tready;
      @(posedge aclk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        if (force_vld) begin
          s_axis_tvalid[i] = 1'b1;
        end else if (rq[i].size() != 0) begin
          if (!s_axis_tvalid[i] || hs[i]) present_cyc[i] = cyc;
          s_axis_tvalid[i]          = 1'b1;
          s_axis_tdata[i*DW +: DW]  = rq[i][0][7:0];
          s_axis_tlast[i]           = rq[i][0][8];
        end else begin
          s_axis_tvalid[i] = 1'b0;
        end
      end
      m_axis_tready = mrdy;
    end
  end

  // Monitor: compare every output handshake and every new grant with the queues.
  initial begin
    forever begin
      @(negedge aclk);
      check("tready_owner_only", 32'(s_axis_tready & ~grant), 32'd0);
      if (m_axis_tvalid && m_axis_tready) begin
        out_cyc = cyc;
        check("out_expected_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check("out_data", 32'(m_axis_tdata), 32'(exp_q[0][7:0]));
          check("out_last", 32'(m_axis_tlast), 32'(exp_q[0][8]));
          void'(exp_q.pop_front());
        end
      end
      if (prev_g == '0 && grant != '0) begin
        grant_cyc = cyc;
        check("grant_expected_pending", 32'(exp_g.size() != 0), 32'd1);
        if (exp_g.size() != 0) begin
          check("grant_owner", 32'(grant), 32'(exp_g[0]));
          void'(exp_g.pop_front());
        end
      end
      prev_g = grant;
    end
  end

  task automatic wait_idle(input string name);
    int t = 0;
    while (pending() && t < 400) begin
      @(negedge aclk);
      t++;
    end
    check({name, "_drained"}, 32'(t < 400), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (4) @(negedge aclk);
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    rq[r].push_back({l, d});
  endtask

  task automatic expect_out(input logic [7:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset with every requester valid.
    repeat (3) @(negedge aclk);
    check("rst_tready", 32'(s_axis_tready), 32'd0);
    check("rst_m_vld", 32'(m_axis_tvalid), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_m_data", 32'(m_axis_tdata), 32'd0);
    check("rst_m_last", 32'(m_axis_tlast), 32'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("rst_sync_edge1_grant", 32'(grant), 32'd0);
    force_vld = 1'b0;
    repeat (4) @(negedge aclk);
    check("rst_no_grant_after_drop", 32'(grant), 32'd0);

    // Single requester, latency.
    push(2, 8'hA5, 1'b1);
    exp_g.push_back(4'b0100);
    expect_out(8'hA5, 1'b1);
    wait_idle("single");
    check("single_grant_latency", 32'(grant_cyc - present_cyc[2]), 32'd1);
    check("single_out_latency", 32'(out_cyc - present_cyc[2]), 32'd2);

    // Round robin over all requesters with 1-beat packets.
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) push(i, 8'(16 * i + k), 1'b1);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin
        exp_g.push_back(4'(1 << i));
        expect_out(8'(16 * i + k), 1'b1);
      end
    wait_idle("rr");

    // Multi-beat packet from req0 competing with req1.
    do_reset();
    push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
    push(1, 8'h44, 1'b1);
`ifdef AXIS_ARB_PACKET_LOCK_EN
    exp_g.push_back(4'b0001); exp_g.push_back(4'b0010);
    expect_out(8'h11, 1'b0); expect_out(8'h22, 1'b0); expect_out(8'h33, 1'b1);
    expect_out(8'h44, 1'b1);
`else
    exp_g.push_back(4'b0001); exp_g.push_back(4'b0010);
    exp_g.push_back(4'b0001); exp_g.push_back(4'b0001);
    expect_out(8'h11, 1'b0); expect_out(8'h44, 1'b1);
    expect_out(8'h22, 1'b0); expect_out(8'h33, 1'b1);
`endif
    wait_idle("pkt");

    // Backpressure: output stalls five cycles holding 0x7E.
    do_reset();
    mrdy = 1'b0;
    repeat (2) @(negedge aclk);
    push(1, 8'h7E, 1'b1); push(1, 8'h5A, 1'b1);
    exp_g.push_back(4'b0010); exp_g.push_back(4'b0010);
    expect_out(8'h7E, 1'b1); expect_out(8'h5A, 1'b1);
    t = 0;
    while (!m_axis_tvalid && t < 50) begin
      @(negedge aclk);
      t++;
    end
    check("bp_vld_seen", 32'(t < 50), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      check("bp_data_held", 32'(m_axis_tdata), 32'h7E);
      check("bp_vld_held", 32'(m_axis_tvalid), 32'd1);
      check("bp_tready_low", 32'(s_axis_tready), 32'd0);
    end
    mrdy = 1'b1;
    wait_idle("bp");

    // Long packet from req3; req0 joins once req3 owns the output.
    do_reset();
    for (int b = 0; b < 10; b++) push(3, 8'(8'h30 + b), 1'(b == 9));
`ifdef AXIS_ARB_PACKET_LOCK_EN
    exp_g.push_back(4'b1000); exp_g.push_back(4'b0001);
    exp_g.push_back(4'b1000); exp_g.push_back(4'b1000);
    for (int b = 0; b < 4; b++) expect_out(8'(8'h30 + b), 1'b0);
    expect_out(8'h01, 1'b1);
    for (int b = 4; b < 10; b++) expect_out(8'(8'h30 + b), 1'(b == 9));
`else
    exp_g.push_back(4'b1000); exp_g.push_back(4'b0001);
    for (int b = 1; b < 10; b++) exp_g.push_back(4'b1000);
    expect_out(8'h30, 1'b0);
    expect_out(8'h01, 1'b1);
    for (int b = 1; b < 10; b++) expect_out(8'(8'h30 + b), 1'(b == 9));
`endif
    t = 0;
    while (grant != 4'b1000 && t < 50) begin
      @(negedge aclk);
      t++;
    end
    check("burst_req3_first", 32'(grant), 32'h8);
    push(0, 8'h01, 1'b1);
    wait_idle("burst");

    // Reset asserted mid-flight drops the held beat immediately.
    do_reset();
    mrdy = 1'b0;
    repeat (2) @(negedge aclk);
    push(0, 8'h55, 1'b1);
    exp_g.push_back(4'b0001);
    t = 0;
    while (!m_axis_tvalid && t < 50) begin
      @(negedge aclk);
      t++;
    end
    check("midrst_vld_seen", 32'(t < 50), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check("midrst_async_vld", 32'(m_axis_tvalid), 32'd0);
    check("midrst_async_grant", 32'(grant), 32'd0);
    mrdy = 1'b1;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    repeat (6) @(negedge aclk);
    check("midrst_no_replay", 32'(m_axis_tvalid), 32'd0);
    wait_idle("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of requester streams (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning tdata width in bits of every stream.
REQ-003 SHALL have parameter MAX_BURST, default 16, meaning the maximum number of beats per grant (1..255).
REQ-004 SHALL have port aclk, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port aresetn, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port s_axis_tvalid, input, N, per-requester valid.
REQ-007 SHALL have port s_axis_tready, output, N, per-requester ready.
REQ-008 SHALL have port s_axis_tdata, input, N*DATA_WIDTH, requester i in slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port s_axis_tlast, input, N, per-requester packet end.
REQ-010 SHALL have port m_axis_tvalid, output, 1, shared-sink valid.
REQ-011 SHALL have port m_axis_tready, input, 1, shared-sink ready.
REQ-012 SHALL have port m_axis_tdata, output, DATA_WIDTH, shared-sink data.
REQ-013 SHALL have port m_axis_tlast, output, 1, shared-sink packet end.
REQ-014 SHALL have port grant, output, N, one-hot current owner; all-zero when idle.

Function
REQ-015 SHALL implement FSM states IDLE and GRANT.
REQ-016 In IDLE with any s_axis_tvalid set: grant the first requester at or above (ptr+1) mod N that has valid set, register it into grant, and go to GRANT next cycle.
REQ-017 In IDLE with no valid set: stay in IDLE, grant = 0.
REQ-018 In GRANT: s_axis_tready[g] = !m_axis_tvalid || m_axis_tready for owner g; all other tready = 0; tready of a non-owner is never 1.
REQ-019 Output stage: a single register with 1-cycle latency from accepted beat to m_axis_*; it loads when s_axis_tvalid[g] && s_axis_tready[g]; m_axis_tvalid clears when m_axis_tready=1 and no new load.
REQ-020 m_axis_tvalid/tdata/tlast SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-021 The 8-bit beat counter SHALL increment per accepted beat in GRANT and clear on entry to GRANT.
REQ-022 Release: on the accepted beat that meets the release condition (REQ-030/031), ptr <= g, grant <= 0, next state = IDLE.
REQ-023 The beat counter reaching MAX_BURST SHALL force release even mid-packet.
REQ-024 The owner deasserting tvalid mid-grant SHALL NOT cause release; the grant holds.
REQ-025 Throughput: exactly one IDLE bubble cycle per grant; back-to-back beats within a grant at 1 beat/cycle when m_axis_tready=1.
REQ-026 Fairness: with all N requesters continuously valid, grants SHALL rotate 0,1,..,N-1,0.

Reset
REQ-027 While aresetn=0 (asynchronous assert): state=IDLE, ptr=N-1 (so requester 0 wins first), counter=0, grant=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0.
REQ-028 Reset mid-grant SHALL discard the output register contents; the beat in flight is lost.
REQ-029 Deassertion is synchronised internally with a 2-flop synchroniser; the first grant is possible no earlier than the 2nd aclk edge after deassertion.

Configuration
REQ-030 With macro AXIS_ARB_PACKET_LOCK_EN defined: release on the accepted beat with s_axis_tlast[g]=1 or with counter = MAX_BURST-1.
REQ-031 Without AXIS_ARB_PACKET_LOCK_EN: release after every accepted beat (beat-level round robin); s_axis_tlast is passed through only; MAX_BURST is unused.

Verification
REQ-032 Reset: hold aresetn=0 with all tvalid=1 -> all s_axis_tready=0, m_axis_tvalid=0, grant=0.
REQ-033 Single requester: N=4, req2 sends 0xA5 with tlast=1 and m_ready=1 -> grant=4'b0100 one cycle after tvalid; 0xA5 on m_axis_tdata one cycle after acceptance, tlast=1.
REQ-034 Round robin: all 4 requesters send 1-beat packets continuously -> grant sequence 0001,0010,0100,1000,0001.
REQ-035 Packet lock (macro on): req0 sends 3-beat packet 0x11,0x22,0x33 while req1 is valid -> m_axis carries 0x11,0x22,0x33 contiguously, then req1 is granted.
REQ-036 Backpressure: m_axis_tready=0 for 5 cycles with 0x7E held -> m_axis_tdata remains 0x7E, owner tready=0, no beat lost or duplicated.
REQ-037 Burst cap: MAX_BURST=4, req3 sends a 10-beat packet while req0 is valid (macro on) -> release after beat 4, req0 granted, then req3 resumes.
